// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state type for the round-robin ALU
// controller.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/eight_bit_ALU.sv
// Purely combinational 8-bit ALU. The carry output is meaningful only for
// add and sub; divide by zero yields zero.
module eight_bit_ALU
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] sel,
    output logic [7:0] y,
    output logic       carry
);

    logic [8:0]  wide;
    logic [15:0] prod;

    always_comb begin
        wide  = 9'd0;
        prod  = 16'(a) * 16'(b);
        y     = 8'd0;
        carry = 1'b0;
        case (sel)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[7:0];
                carry = wide[8];
            end
            // A borrow shows up as bit 8 of the wrapped difference.
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                y     = wide[7:0];
                carry = wide[8];
            end
            OP_MUL:  y = prod[7:0];
            OP_DIV:  y = (b == 8'd0) ? 8'd0 : a / b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~a;
        endcase
    end

endmodule

// File: rtl/alu_rr_ctrl.sv
// Two-requester round-robin front end for eight_bit_ALU (IDLE -> EXEC -> RESP).
// Define ALU_DIVZ_ERR_EN to add the rsp_err divide-by-zero flag.
module alu_rr_ctrl
    import alu_pkg::*;
#(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic       rsp_carry,
`ifdef ALU_DIVZ_ERR_EN
    output logic       rsp_err,
`endif
    output logic       busy
);

    state_t     state;
    logic       ptr;
    logic [7:0] a_q, b_q;
    logic [2:0] sel_q;
    logic       id_q;

    logic       grant_id;
    logic       take;
    logic [7:0] alu_y;
    logic       alu_c;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant_id;
        req1_ready = !rst && (state == IDLE) && req1_valid &&  grant_id;
        take       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    eight_bit_ALU u_alu (
        .a     (a_q),
        .b     (b_q),
        .sel   (sel_q),
        .y     (alu_y),
        .carry (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= INIT_PRIO;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            sel_q     <= 3'd0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= 8'd0;
            rsp_carry <= 1'b0;
`ifdef ALU_DIVZ_ERR_EN
            rsp_err   <= 1'b0;
`endif
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_q   <= grant_id ? req1_a   : req0_a;
                        b_q   <= grant_id ? req1_b   : req0_b;
                        sel_q <= grant_id ? req1_sel : req0_sel;
                        id_q  <= grant_id;
                        ptr   <= ~grant_id;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_carry <= alu_c;
                    rsp_id    <= id_q;
`ifdef ALU_DIVZ_ERR_EN
                    rsp_err   <= (sel_q == OP_DIV) && (b_q == 8'd0);
`endif
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_rr_ctrl.md
ALU_RR_CTRL -- requirements
Module: alu_rr_ctrl

Interface
REQ-001 Parameter: INIT_PRIO, 0, requester that wins the first contended grant after reset (0 or 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) holds an operation.
REQ-005 reqN_ready  output  1  controller accepts requester N this cycle.
REQ-006 reqN_a, reqN_b  input  8 each  operands of requester N.
REQ-007 reqN_sel  input  3  opcode of requester N (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 not A).
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result.
REQ-010 rsp_id  output  1  requester that issued the result.
REQ-011 rsp_y  output  8  result; rsp_carry  output  1  carry/borrow flag.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP.
REQ-014 IDLE: grant = only valid requester; if both valid, requester equal to priority pointer.
REQ-015 reqN_ready SHALL be high only in IDLE for the granted requester; combinational from valids, pointer and state.
REQ-016 Handshake on reqN_valid && reqN_ready: latch a, b, sel, id; go to EXEC; pointer becomes other requester.
REQ-017 Requesters SHALL hold valid and payload stable until accepted; controller never drops an offered operation.
REQ-018 EXEC (one cycle): evaluate latched operands, register y/carry into response registers; go to RESP.
REQ-019 RESP: rsp_valid high, rsp_* stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE.
REQ-020 Latency: accept at edge N, rsp_valid high after edge N+2; best throughput one operation per 3 cycles.
REQ-021 Arithmetic: add/sub SHALL produce 9-bit result {carry,y}; sub borrow sets carry.
REQ-022 mul SHALL give low 8 bits of product; div SHALL give A/B, y=0 when B=0; all non-add/sub ops give carry=0.
REQ-023 No request accepted while busy; both readies low in EXEC and RESP.
REQ-024 Pointer SHALL not change when no handshake occurs.

Reset
REQ-025 On rst: state IDLE, pointer = INIT_PRIO, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_carry=0, busy=0, latched operands cleared.
REQ-026 rst during EXEC or RESP SHALL abort the operation; no response emitted for it.
REQ-027 reqN_ready SHALL be low in any cycle where rst is high.

Configuration
REQ-028 Macro ALU_DIVZ_ERR_EN: when defined, output rsp_err (1 bit) SHALL be added, set with the response when sel=011 and B=0, else 0; reset value 0.
REQ-029 Without ALU_DIVZ_ERR_EN: no rsp_err port; divide-by-zero silently yields y=0, carry=0.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants (OP_ADD..OP_NOT) and the FSM state typedef.
REQ-031 Datapath SHALL be the team's existing 8-bit ALU module (eight_bit_ALU) instantiated once, fed from latched operands; arbitration and FSM stay in alu_rr_ctrl.

Verification
REQ-032 req0 a=200 b=100 sel=000 -> rsp_y=44, rsp_carry=1, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-033 req1 a=5 b=10 sel=001 -> rsp_y=251, rsp_carry=1, rsp_id=1; a=12 b=13 sel=010 -> rsp_y=156, carry=0.
REQ-034 After reset (INIT_PRIO=0), both valid continuously -> grants alternate 0,1,0,1; neither starved.
REQ-035 rsp_ready held low 5 cycles -> rsp_* stable, busy=1, both readies low; accept on 6th cycle, IDLE next.
REQ-036 a=50 b=0 sel=011 -> rsp_y=0, carry=0; rsp_err=1 only with ALU_DIVZ_ERR_EN.
REQ-037 rst pulsed in EXEC -> next cycle IDLE, rsp_valid=0, pointer=INIT_PRIO, no stale response afterwards.
